bp_cfg_loader: RTL
==================

# bp_cfg_loader

Parametrised configuration sequencer that streams a programmable table of (address, data) writes onto the configuration bus to every core in a multicore tile. It supports a per-core unicast sweep and a single-pass broadcast. It sits between the host/debug front end and the per-core cfg endpoints. It replaces the fixed, elaboration-time per-core settings with a run-time loadable, depth- and core-count-generic write engine.

## Interface
- num_core_p, 1: number of cores addressed; 1..2^cfg_core_width_p-2.
- num_entries_p, 4: table depth; ≥1.
- cfg_core_width_p, 8: core id width.
- cfg_addr_width_p, 16: cfg register address width.
- cfg_data_width_p, 64: cfg data width.
- Broadcast core id is fixed at all-ones of cfg_core_width_p.

- clk_i  in  1  clock; all state on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- table_w_v_i  in  1  table write strobe.
- table_w_idx_i  in  clog2(num_entries_p)  entry index.
- table_addr_i  in  cfg_addr_width_p  entry cfg address.
- table_data_i  in  cfg_data_width_p  entry cfg data.
- table_clr_i  in  1  clear all entry valid bits.
- mode_i  in  1  0 = unicast sweep, 1 = broadcast; sampled at start.
- start_i  in  1  begin sweep.
- busy_o  out  1  high in SEND.
- done_o  out  1  one-cycle completion pulse.
- cfg_v_o  out  1  cfg write valid.
- cfg_ready_i  in  1  cfg write accepted.
- cfg_core_o  out  cfg_core_width_p  target core id.
- cfg_addr_o  out  cfg_addr_width_p  cfg address.
- cfg_data_o  out  cfg_data_width_p  cfg data.

## Operation
- Table: num_entries_p registers, each holding {valid, addr, data}.
  - A write in IDLE or DONE with table_w_v_i stores addr/data and sets valid.
  - table_clr_i in IDLE or DONE clears all valid bits. If table_w_v_i and table_clr_i are both high, clear wins.
  - Table writes and clears in SEND are ignored.
- The state machine has three states:
  - IDLE --start_i--> SEND. On this transition it latches mode_i into mode_r and zeroes entry_idx and core_idx.
  - SEND --last step--> DONE.
  - DONE --> IDLE unconditionally.
  - start_i is ignored outside IDLE.
- Sweep order: entry_idx is the inner loop (0..num_entries_p-1); core_idx is the outer loop (0..num_core_p-1). In broadcast mode the outer loop runs once.
- Step rule in SEND:
  - If the current entry is valid, cfg_v_o=1 and the step completes on a cycle with cfg_v_o & cfg_ready_i.
  - If the current entry is invalid, cfg_v_o=0 and the step completes in that cycle with no bus transfer.
- Step completion advances the counters:
  - entry_idx wraps to 0 after num_entries_p-1, and core_idx then increments.
  - The last step is entry num_entries_p-1 of core num_core_p-1 (unicast) or of pass 0 (broadcast).
- Payload while cfg_v_o=1:
  - cfg_core_o = core_idx in unicast mode, or all-ones in broadcast mode.
  - cfg_addr_o and cfg_data_o come from the table entry at entry_idx.
- Outputs are forced to zero whenever cfg_v_o=0.
- Once cfg_v_o=1, the payload holds stable until it is accepted (no retraction).
- Counter widths: clog2 of the respective bound, with a 1-bit minimum. No counter overflows past its bound.

## Timing
- Reset (asynchronous assert, synchronous-to-clk_i deassert expected):
  - State goes to IDLE; counters go to 0; mode_r goes to 0; all valid bits are cleared.
  - busy_o, done_o, cfg_v_o, cfg_core_o, cfg_addr_o and cfg_data_o are all 0.
  - Table addr/data need not be reset.
- Reset asserted mid-sweep aborts the sweep immediately. No done_o pulse is produced, and the table contents are lost (valid bits cleared).
- start_i seen high at edge t means SEND from t+1. cfg_v_o may assert in the cycle after edge t.
- One step completes per cycle at best, so an all-valid unicast sweep with cfg_ready_i tied high takes num_core_p*num_entries_p cycles in SEND.
- Each cycle with cfg_ready_i=0 against cfg_v_o=1 adds one cycle.
- If the last step completes at edge e, then done_o=1 and busy_o=0 during the cycle after e. IDLE follows one cycle later.
- busy_o is derived from state (registered); done_o is high only in DONE; cfg_v_o is a function of state, valid bit and entry_idx.
- A new start_i is accepted in IDLE the cycle after DONE at the earliest. Back-to-back sweeps therefore have a 2-cycle gap: DONE, then IDLE.

## Test plan
- Reset: hold reset_n_i=0 mid-clock with random inputs -> all outputs 0 asynchronously; after release, busy_o=0 and start_i with an empty table produces num_entries_p silent steps, then done_o.
- Unicast sweep:
  - Setup: num_core_p=2, entries {0:(0x0010,0xA), 1:(0x0020,0xB)}, cfg_ready_i=1.
  - Required response: writes in the order (core0,0x0010,0xA), (core0,0x0020,0xB), (core1,0x0010,0xA), (core1,0x0020,0xB), then done_o one cycle later.
- Broadcast: same table, mode_i=1 -> exactly 2 writes with cfg_core_o=0xFF, then done_o.
- Backpressure and skip:
  - Setup: entry 1 invalid; cfg_ready_i low for 3 cycles on the first write.
  - Required response: payload stable for 4 cycles; entry 1 produces no cfg_v_o; total SEND cycles = 2*(entries) + 3.
- Ignored inputs during SEND: start_i, table_w_v_i and table_clr_i pulsed during SEND -> no restart, and the table is unchanged on the next sweep.
- Mid-sweep reset: assert reset_n_i during the second write -> cfg_v_o drops the same cycle; the following sweep with no table writes emits no cfg writes.

Source files
------------

// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: run-time loadable cfg write sequencer.
// Streams a table of (addr, data) writes to each core or as one broadcast pass.
module bp_cfg_loader #(
  parameter int num_core_p       = 1,
  parameter int num_entries_p    = 4,
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  localparam int EW = (num_entries_p > 1) ? $clog2(num_entries_p) : 1,
  localparam int CW = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        table_w_v_i,
  input  logic [EW-1:0]               table_w_idx_i,
  input  logic [cfg_addr_width_p-1:0] table_addr_i,
  input  logic [cfg_data_width_p-1:0] table_data_i,
  input  logic                        table_clr_i,
  input  logic                        mode_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [EW-1:0] entry_q, entry_d;
  logic [CW-1:0] core_q, core_d;
  logic mode_q, mode_d;
  logic [num_entries_p-1:0] valid_q, valid_d;

  logic [cfg_addr_width_p-1:0] addr_q [num_entries_p];
  logic [cfg_data_width_p-1:0] data_q [num_entries_p];

  logic tbl_open;
  logic idx_ok;
  logic tbl_we;
  logic cur_v;
  logic step;
  logic last_entry;
  logic last_core;

  always_comb begin
    tbl_open   = (state_q != SEND);
    idx_ok     = (32'(table_w_idx_i) < num_entries_p);
    tbl_we     = tbl_open && table_w_v_i && !table_clr_i && idx_ok;
    cur_v      = (state_q == SEND) && valid_q[entry_q];
    step       = (state_q == SEND) && (!valid_q[entry_q] || cfg_ready_i);
    last_entry = (entry_q == EW'(num_entries_p - 1));
    last_core  = mode_q || (core_q == CW'(num_core_p - 1));

    state_d = state_q;
    entry_d = entry_q;
    core_d  = core_q;
    mode_d  = mode_q;
    valid_d = valid_q;

    if (tbl_open && table_clr_i) begin
      valid_d = '0;
    end else if (tbl_we) begin
      valid_d[table_w_idx_i] = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SEND;
          mode_d  = mode_i;
          entry_d = '0;
          core_d  = '0;
        end
      end
      SEND: begin
        if (step) begin
          if (last_entry) begin
            entry_d = '0;
            if (last_core) state_d = DONE;
            else core_d = core_q + CW'(1);
          end else begin
            entry_d = entry_q + EW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      entry_q <= '0;
      core_q  <= '0;
      mode_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      core_q  <= core_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage carries no reset; the valid bits gate its use.
  always_ff @(posedge clk_i) begin
    if (tbl_we) begin
      addr_q[table_w_idx_i] <= table_addr_i;
      data_q[table_w_idx_i] <= table_data_i;
    end
  end

  always_comb begin
    busy_o     = (state_q == SEND);
    done_o     = (state_q == DONE);
    cfg_v_o    = cur_v;
    cfg_core_o = '0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    if (cur_v) begin
      cfg_core_o = mode_q ? '1 : cfg_core_width_p'(core_q);
      cfg_addr_o = addr_q[entry_q];
      cfg_data_o = data_q[entry_q];
    end
  end

endmodule
